aes_128_sched_ncyc: RTL and testbench

- Parametrised scheduler/controller for the iterative AES-128 round datapath. It is the next generation of the fixed 4-cycle control path.
- Adds a configurable cycles-per-round (1/2/4) and an input FIFO, so back-to-back blocks queue instead of colliding.
- Sits between the user block interface and the round datapath plus key schedule.
- Drives start/mixcol/round index to the datapath and key requests to the key schedule, and flags the returned datapath result valid.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_sync_fifo.sv | 53 +++++
 rtl/aes_128_sched_ncyc.sv | 77 +++++++
 tb/tb_aes_128_sched_ncyc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES scheduler constants, state encoding and parameter checks
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int AES_W = 128;
  typedef logic [1:0] sched_st_t;
  localparam sched_st_t ST_IDLE = 2'd0;
  localparam sched_st_t ST_LOAD = 2'd1;
  localparam sched_st_t ST_ROUND = 2'd2;
  localparam sched_st_t ST_DONE = 2'd3;
  function automatic bit cyc_ok(input int c);
    return c == 1 || c == 2 || c == 4;
  endfunction
endpackage

// File: rtl/aes_sync_fifo.sv
// aes_sync_fifo: single-clock block FIFO with registered flags and no bypass
module aes_sync_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    kill,
  input  logic                    push_i,
  input  logic [W-1:0]            wdata_i,
  input  logic                    pop_i,
  output logic [W-1:0]            rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("aes_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q, level_d;
  logic full_q, empty_q, do_push, do_pop;
  // a push is refused on the registered full flag, even if a pop frees space this cycle
  always_comb begin
    do_push = push_i && !full_q;
    do_pop = pop_i && !empty_q;
    level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge kill)
    if (kill) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      level_q <= level_d;
      full_q <= level_d == FULL_LVL;
      empty_q <= level_d == '0;
    end
  // storage is not reset; entries are only read after being written
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
  assign rdata_o = mem_q[rd_q];
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;
endmodule

// File: rtl/aes_128_sched_ncyc.sv
// aes_128_sched_ncyc: queued AES-128 round scheduler with 1/2/4 cycles per round
module aes_128_sched_ncyc import aes_pkg::*; #(
  parameter int W = AES_W,
  parameter int CYC = 4,
  parameter int NR = AES_NR,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    kill,
  input  logic [W-1:0]            in_data,
  input  logic                    in_en,
  output logic                    in_ready,
  output logic [W-1:0]            core_data,
  output logic                    core_start,
  output logic                    core_en_mixcol,
  output logic [3:0]              core_round,
  output logic                    key_req,
  output logic                    out_en,
  output logic                    idle,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    in_en_collision_irq_pulse
);
  if (!cyc_ok(CYC)) begin : g_bad_cyc
    $error("aes_128_sched_ncyc: CYC must be 1, 2 or 4");
  end
  localparam logic [1:0] CYC_MAX = 2'(CYC - 1);
  localparam logic [3:0] RND_MAX = 4'(NR);
  sched_st_t st_q, st_d, st_eff;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] cyc_q, cyc_d;
  logic irq_q, full, empty, load, last_cyc;
  logic [W-1:0] head;
  aes_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .kill(kill),
    .push_i(in_en),
    .wdata_i(in_data),
    .pop_i(load),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(fifo_level)
  );
  // LOAD is never registered: IDLE or DONE with a queued block load in the same cycle
  always_comb begin
    load = (st_q == ST_IDLE || st_q == ST_DONE) && !empty;
    st_eff = load ? ST_LOAD : st_q;
    last_cyc = cyc_q == CYC_MAX;
    st_d = st_eff == ST_LOAD ? ST_ROUND :
           st_eff == ST_DONE ? ST_IDLE :
           (st_eff == ST_ROUND && last_cyc && rnd_q == RND_MAX) ? ST_DONE : st_eff;
    rnd_d = load ? 4'd1 : (st_q == ST_ROUND && last_cyc && rnd_q != RND_MAX) ? rnd_q + 4'd1 : rnd_q;
    cyc_d = (st_q == ST_ROUND && !last_cyc) ? cyc_q + 2'd1 : 2'd0;
  end
  // state, round/cycle counters and the dropped-push flag
  always_ff @(posedge clk or posedge kill)
    if (kill) begin
      st_q <= ST_IDLE;
      rnd_q <= 4'd0;
      cyc_q <= 2'd0;
      irq_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rnd_q <= rnd_d;
      cyc_q <= cyc_d;
      irq_q <= in_en && full;
    end
  assign in_ready = !full;
  assign core_start = load;
  assign core_data = load ? head : '0;
  assign core_round = load ? 4'd0 : rnd_q;
  assign key_req = load || (st_q == ST_ROUND && cyc_q == 2'd0);
  assign core_en_mixcol = st_q == ST_ROUND && rnd_q != RND_MAX;
  assign out_en = st_q == ST_DONE;
  assign idle = st_q == ST_IDLE && empty;
  assign in_en_collision_irq_pulse = irq_q;
endmodule

// File: tb/tb_aes_128_sched_ncyc.sv
// tb_aes_128_sched_ncyc: randomized and directed checks against a block-timeline model
module tb_aes_128_sched_ncyc;
  localparam int CYC = 4, NR = 10, DEPTH = 4, LAST = NR * CYC + 1;
  logic clk = 0, kill = 1, in_en = 0, en_b = 0;
  logic [127:0] in_data = '0, data_b = '0;
  logic in_ready, core_start, mixcol, key_req, out_en, idle, irq;
  logic [127:0] core_data;
  logic [3:0] core_round;
  logic [2:0] fifo_level;
  logic c1_rdy, c1_start, c1_mix, c1_key, c1_out, c1_idle, c1_irq;
  logic [127:0] c1_data;
  logic [3:0] c1_round;
  logic [2:0] c1_lvl;
  logic c2_rdy, c2_start, c2_mix, c2_key, c2_out, c2_idle, c2_irq;
  logic [127:0] c2_data;
  logic [3:0] c2_round;
  logic [2:0] c2_lvl;
  int n_chk = 0, n_err = 0;
  logic [127:0] mq[$];
  bit busy = 0, irq_m = 0;
  int t = 0;

  aes_128_sched_ncyc #(.W(128), .CYC(CYC), .NR(NR), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .kill(kill), .in_data(in_data), .in_en(in_en), .in_ready(in_ready),
    .core_data(core_data), .core_start(core_start), .core_en_mixcol(mixcol), .core_round(core_round),
    .key_req(key_req), .out_en(out_en), .idle(idle), .fifo_level(fifo_level),
    .in_en_collision_irq_pulse(irq));
  aes_128_sched_ncyc #(.W(128), .CYC(1), .NR(NR), .DEPTH(DEPTH)) u_c1 (
    .clk(clk), .kill(kill), .in_data(data_b), .in_en(en_b), .in_ready(c1_rdy),
    .core_data(c1_data), .core_start(c1_start), .core_en_mixcol(c1_mix), .core_round(c1_round),
    .key_req(c1_key), .out_en(c1_out), .idle(c1_idle), .fifo_level(c1_lvl),
    .in_en_collision_irq_pulse(c1_irq));
  aes_128_sched_ncyc #(.W(128), .CYC(2), .NR(NR), .DEPTH(DEPTH)) u_c2 (
    .clk(clk), .kill(kill), .in_data(data_b), .in_en(en_b), .in_ready(c2_rdy),
    .core_data(c2_data), .core_start(c2_start), .core_en_mixcol(c2_mix), .core_round(c2_round),
    .key_req(c2_key), .out_en(c2_out), .idle(c2_idle), .fifo_level(c2_lvl),
    .in_en_collision_irq_pulse(c2_irq));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!idle && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, idle, 1);
    step();
  endtask

  // model: each popped block follows a fixed timeline t=0 (load) .. LAST (out_en)
  always @(negedge clk) begin
    if (kill) begin
      mq.delete();
      busy = 0;
      irq_m = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_idle", idle, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_start", core_start, 0);
      chk("rst_out_en", out_en, 0);
      chk("rst_key_req", key_req, 0);
      chk("rst_mixcol", mixcol, 0);
      chk("rst_round", core_round, 0);
      chk("rst_irq", irq, 0);
    end else begin
      bit ld, dn, rd;
      int rnd;
      dn = busy && t == LAST;
      ld = mq.size() > 0 && (!busy || dn);
      rd = busy && t <= NR * CYC;
      rnd = rd ? (t - 1) / CYC + 1 : NR;
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("fifo_level", fifo_level, mq.size());
      chk("idle", idle, !busy && mq.size() == 0);
      chk("irq", irq, irq_m);
      chk("out_en", out_en, dn);
      chk("core_start", core_start, ld);
      if (ld) chk("core_data", core_data, mq[0]);
      chk("key_req", key_req, ld || (rd && (t - 1) % CYC == 0));
      chk("mixcol", mixcol, rd && rnd < NR);
      if (ld || busy) chk("core_round", core_round, ld ? 0 : rnd);
      irq_m = in_en && mq.size() >= DEPTH;
      if (ld) begin
        void'(mq.pop_front());
        busy = 1;
        t = 1;
      end else if (dn) busy = 0;
      else if (busy) t++;
      if (in_en && !irq_m) mq.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ks, ko, nk, nm, nirq, nout, maxl, nrdy0, novl, prev, s1, s2, o1, o2, m1, m2;
    int outs[$];
    repeat (3) step();
    kill = 0;
    step();
    // single block: literal timeline
    in_data = rnd128();
    in_en = 1;
    step();
    in_en = 0;
    ks = -1; ko = -1; nk = 0; nm = 0;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      if (core_start && ks < 0) ks = k;
      if (out_en && ko < 0) ko = k;
      nk += int'(key_req);
      nm += int'(mixcol);
      if (k == 38) chk("p1_mix_round10", mixcol, 0);
      if (k == 41) chk("p1_round10", core_round, 10);
      if (k == 43) chk("p1_idle_after", idle, 1);
    end
    chk("p1_start_cycle", ks, 1);
    chk("p1_out_cycle", ko, 42);
    chk("p1_key_pulses", nk, 11);
    chk("p1_mix_high", nm, 36);
    step();
    // back-to-back burst
    for (int i = 0; i < 4; i++) begin
      in_data = rnd128();
      in_en = 1;
      step();
    end
    in_en = 0;
    nirq = 0; novl = 0;
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      nirq += int'(irq);
      if (out_en) outs.push_back(i);
      if (out_en && core_start) novl++;
    end
    chk("p2_out_count", outs.size(), 4);
    chk("p2_irq_none", nirq, 0);
    chk("p2_start_on_out", novl, 3);
    for (int i = 1; i < outs.size(); i++) chk("p2_spacing", outs[i] - outs[i-1], 41);
    wait_idle("p2_idle_timeout");
    // overflow while busy
    nirq = 0; nout = 0; maxl = 0; nrdy0 = 0;
    for (int i = 0; i < 260; i++) begin
      in_en = (i == 0) || (i >= 4 && i < 10);
      in_data = rnd128();
      @(negedge clk);
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      nirq += int'(irq);
      nout += int'(out_en);
      nrdy0 += int'(!in_ready);
      step();
    end
    in_en = 0;
    chk("p3_max_level", maxl, 4);
    chk("p3_irq_count", nirq, 2);
    chk("p3_out_count", nout, 5);
    chk("p3_ready_dropped", nrdy0 > 0, 1);
    wait_idle("p3_idle_timeout");
    // push coincident with the DONE-cycle pop of a full FIFO
    for (int i = 0; i < 45; i++) begin
      in_en = (i == 0) || (i >= 2 && i < 6) || (i == 42);
      in_data = rnd128();
      @(negedge clk);
      if (i == 42) begin
        chk("p4_level_full", fifo_level, 4);
        chk("p4_out_and_start", {out_en, core_start}, 2'b11);
      end
      if (i == 43) begin
        chk("p4_irq", irq, 1);
        chk("p4_level_after", fifo_level, 3);
      end
      step();
    end
    in_en = 0;
    wait_idle("p4_idle_timeout");
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_en = $urandom_range(0, 9) < 2;
      in_data = rnd128();
      step();
    end
    in_en = 0;
    wait_idle("p5_idle_timeout");
    // asynchronous kill during round 5 with two blocks queued
    for (int i = 0; i < 19; i++) begin
      in_en = i < 3;
      in_data = rnd128();
      step();
    end
    in_en = 0;
    chk("p6_round5", core_round, 5);
    chk("p6_level2", fifo_level, 2);
    #1 kill = 1;
    #1;
    chk("p6_kill_round", core_round, 0);
    chk("p6_kill_level", fifo_level, 0);
    chk("p6_kill_idle", idle, 1);
    chk("p6_kill_ready", in_ready, 1);
    chk("p6_kill_key", key_req, 0);
    @(negedge clk);
    step();
    kill = 0;
    nout = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      nout += int'(out_en);
    end
    chk("p6_no_out_after_kill", nout, 0);
    chk("p6_idle_after_kill", idle, 1);
    step();
    // CYC=1 and CYC=2 builds
    data_b = rnd128();
    en_b = 1;
    step();
    en_b = 0;
    s1 = -1; s2 = -1; o1 = -1; o2 = -1; m1 = 0; m2 = 0; prev = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (c1_start && s1 < 0) s1 = k;
      if (c2_start && s2 < 0) s2 = k;
      if (c1_out && o1 < 0) o1 = k;
      if (c2_out && o2 < 0) o2 = k;
      m1 += int'(c1_mix);
      m2 += int'(c2_mix);
      if (c1_round == 4'd10 && c1_mix) prev++;
      if (c2_round == 4'd10 && c2_mix) prev++;
    end
    chk("c1_start", s1, 1);
    chk("c2_start", s2, 1);
    chk("c1_latency", o1 - s1, 11);
    chk("c2_latency", o2 - s2, 21);
    chk("c1_mix_high", m1, 9);
    chk("c2_mix_high", m2, 18);
    chk("c12_mix_round10", prev, 0);
    chk("c12_idle", {c1_idle, c2_idle}, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
